// File: rtl/hcu_dispatch_pkg.sv
// hcu_dispatch shared types: input FSM states, engine id type and
// the round-robin free-engine search.
package hcu_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    STREAM
  } state_t;

  // Wide enough for the largest supported engine count (8).
  localparam int ENG_W = 3;
  typedef logic [ENG_W-1:0] eng_id_t;

  function automatic eng_id_t rr_pick(
    input logic [7:0] busy,
    input eng_id_t    ptr,
    input int         n
  );
    eng_id_t pick;
    logic    found;
    int      idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && !busy[idx]) begin
        pick  = eng_id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hcu_order_fifo.sv
// Synchronous FIFO of engine ids recording message arrival order.
// First-word-fall-through: o_head is valid whenever o_empty is low.
module hcu_order_fifo
  import hcu_dispatch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    axis_aclk,
  input  logic    reset,
  input  logic    i_push,
  input  eng_id_t i_din,
  input  logic    i_pop,
  output eng_id_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  eng_id_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge axis_aclk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)
        r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hcu_dispatch.sv
// Shares N_ENGINES hcu engines between whole messages; digests return in
// arrival order. HCU_DISPATCH_STATS_EN adds stat_msgs/stat_stall counters.
module hcu_dispatch
  import hcu_dispatch_pkg::*;
#(
  parameter int N_ENGINES           = 4,
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 512,
  parameter int C_AXIS_TUSER_WIDTH  = 128,
  parameter int ORDER_DEPTH         = 8
) (
  input  logic                                     axis_aclk,
  input  logic                                     reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]            s_axis_tuser,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  input  logic                                     s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic                                     m_axis_tlast,
  output logic [N_ENGINES*C_S_AXIS_DATA_WIDTH-1:0] e_axis_tdata,
  output logic [N_ENGINES*C_AXIS_TUSER_WIDTH-1:0]  e_axis_tuser,
  output logic [N_ENGINES-1:0]                     e_axis_tvalid,
  output logic [N_ENGINES-1:0]                     e_axis_tlast,
  input  logic [N_ENGINES-1:0]                     e_axis_tready,
  input  logic [N_ENGINES*C_M_AXIS_DATA_WIDTH-1:0] d_axis_tdata,
  input  logic [N_ENGINES*C_AXIS_TUSER_WIDTH-1:0]  d_axis_tuser,
  input  logic [N_ENGINES-1:0]                     d_axis_tvalid,
  output logic [N_ENGINES-1:0]                     d_axis_tready
`ifdef HCU_DISPATCH_STATS_EN
  ,
  output logic [31:0]                              stat_msgs,
  output logic [31:0]                              stat_stall
`endif
);

  localparam int SW = C_S_AXIS_DATA_WIDTH;
  localparam int MW = C_M_AXIS_DATA_WIDTH;
  localparam int UW = C_AXIS_TUSER_WIDTH;

  if (N_ENGINES < 2 || N_ENGINES > 8 || ORDER_DEPTH < N_ENGINES) begin : g_bad_cfg
    $error("hcu_dispatch: need 2<=N_ENGINES<=8 and ORDER_DEPTH>=N_ENGINES");
  end

  state_t                r_state;
  state_t                w_state_nx;
  logic [N_ENGINES-1:0]  r_busy;
  eng_id_t               r_sel;
  eng_id_t               r_rr;
  eng_id_t               w_pick;
  eng_id_t               w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_pick = rr_pick(8'(r_busy), r_rr, N_ENGINES);

  // Message data fans out to every engine; only the selected one sees valid.
  always_comb begin
    w_state_nx    = r_state;
    w_push        = 1'b0;
    s_axis_tready = 1'b0;
    e_axis_tdata  = {N_ENGINES{s_axis_tdata}};
    e_axis_tuser  = {N_ENGINES{s_axis_tuser}};
    e_axis_tvalid = '0;
    e_axis_tlast  = '0;
    unique case (r_state)
      IDLE: begin
        if (s_axis_tvalid && !(&r_busy) && !w_full)
          w_state_nx = SELECT;
      end
      SELECT: w_state_nx = STREAM;
      STREAM: begin
        for (int k = 0; k < N_ENGINES; k++) begin
          if (eng_id_t'(k) == r_sel) begin
            s_axis_tready    = e_axis_tready[k];
            e_axis_tvalid[k] = s_axis_tvalid;
            e_axis_tlast[k]  = s_axis_tlast;
          end
        end
        if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
          w_push     = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    d_axis_tready = '0;
    for (int k = 0; k < N_ENGINES; k++) begin
      if (!w_empty && eng_id_t'(k) == w_head) begin
        m_axis_tvalid    = d_axis_tvalid[k];
        m_axis_tdata     = d_axis_tdata[k*MW +: MW];
        m_axis_tuser     = d_axis_tuser[k*UW +: UW];
        d_axis_tready[k] = m_axis_tready;
      end
    end
  end

  assign m_axis_tlast = m_axis_tvalid;
  assign w_pop        = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= '0;
      r_sel   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == SELECT) begin
        r_sel <= w_pick;
        r_rr  <= (w_pick == eng_id_t'(N_ENGINES - 1)) ? '0 : w_pick + 1'b1;
      end
      for (int k = 0; k < N_ENGINES; k++) begin
        if (w_pop && eng_id_t'(k) == w_head) r_busy[k] <= 1'b0;
        if (w_push && eng_id_t'(k) == r_sel) r_busy[k] <= 1'b1;
      end
    end
  end

  hcu_order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .axis_aclk (axis_aclk),
    .reset     (reset),
    .i_push    (w_push),
    .i_din     (r_sel),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

`ifdef HCU_DISPATCH_STATS_EN
  logic [31:0] r_msgs;
  logic [31:0] r_stall;

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      r_msgs  <= '0;
      r_stall <= '0;
    end else begin
      if (w_pop && r_msgs != '1)
        r_msgs <= r_msgs + 32'd1;
      if (s_axis_tvalid && r_state == IDLE && (&r_busy) && r_stall != '1)
        r_stall <= r_stall + 32'd1;
    end
  end

  assign stat_msgs  = r_msgs;
  assign stat_stall = r_stall;
`endif

endmodule
